// File: rtl/bsg_down_io_rx_buffer.sv
// ============================================================================
// Module      : bsg_down_io_rx_buffer
// Description : IO-side receive buffer for the downstream channel. It packs
//               IO bytes into 16-bit half-words and returns link credits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_down_io_rx_buffer #(
    parameter int DEPTH_LG    = 6,
    parameter int TOKEN_BATCH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                io_valid_in,
    input  logic [7:0]          io_data_in,
    output logic                io_token_out,
    output logic                half_valid_o,
    output logic [15:0]         half_data_o,
    input  logic                half_ready_i,
    output logic                full_o,
    output logic                empty_o,
    output logic [DEPTH_LG:0]   count_o,
    output logic                overflow_o
);

    localparam int              c_PW      = DEPTH_LG + 1;
    localparam int              c_DEPTH   = 1 << DEPTH_LG;
    localparam int              c_TCW     = (TOKEN_BATCH > 1) ? $clog2(TOKEN_BATCH) : 1;
    localparam logic [c_PW-1:0] c_FULL    = c_PW'(c_DEPTH);
    localparam logic [c_PW-1:0] c_TWO     = c_PW'(2);
    localparam logic [c_TCW-1:0] c_TB_LAST = c_TCW'(TOKEN_BATCH - 1);

    logic [7:0]          mem [c_DEPTH];

    logic [c_PW-1:0]     wptr_q, wptr_d;
    logic [c_PW-1:0]     rptr_q, rptr_d;
    logic                half_valid_q, half_valid_d;
    logic [15:0]         half_data_q, half_data_d;
    logic                overflow_q, overflow_d;
    logic                token_q, token_d;
    logic [c_TCW-1:0]    tcnt_q, tcnt_d;

    logic [c_PW-1:0]     w_count;
    logic [c_PW-1:0]     w_rptr_p1;
    logic                w_full;
    logic                w_empty;
    logic                w_write;
    logic                w_load;
    logic                w_handshake;

    // Status is derived only from registered pointers: no read/write bypass.
    assign w_count     = wptr_q - rptr_q;
    assign w_full      = (w_count == c_FULL);
    assign w_empty     = (w_count == '0);
    assign w_rptr_p1   = rptr_q + c_PW'(1);
    assign w_write     = io_valid_in & ~w_full;
    assign w_handshake = half_valid_q & half_ready_i;
    assign w_load      = (~half_valid_q | half_ready_i) & (w_count >= c_TWO);

    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        half_valid_d = half_valid_q;
        half_data_d  = half_data_q;
        overflow_d   = overflow_q;
        token_d      = 1'b0;
        tcnt_d       = tcnt_q;

        if (w_write) begin
            wptr_d = wptr_q + c_PW'(1);
        end
        if (io_valid_in & w_full) begin
            overflow_d = 1'b1;
        end

        if (w_load) begin
            half_data_d  = {mem[w_rptr_p1[DEPTH_LG-1:0]], mem[rptr_q[DEPTH_LG-1:0]]};
            rptr_d       = rptr_q + c_TWO;
            half_valid_d = 1'b1;
        end else if (w_handshake) begin
            half_valid_d = 1'b0;
        end

        if (w_handshake) begin
            if (tcnt_q == c_TB_LAST) begin
                tcnt_d  = '0;
                token_d = 1'b1;
            end else begin
                tcnt_d = tcnt_q + c_TCW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            half_valid_q <= 1'b0;
            half_data_q  <= '0;
            overflow_q   <= 1'b0;
            token_q      <= 1'b0;
            tcnt_q       <= '0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            half_valid_q <= half_valid_d;
            half_data_q  <= half_data_d;
            overflow_q   <= overflow_d;
            token_q      <= token_d;
            tcnt_q       <= tcnt_d;
        end
    end

    // Storage is deliberately not reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && w_write) begin
            mem[wptr_q[DEPTH_LG-1:0]] <= io_data_in;
        end
    end

    assign io_token_out = token_q;
    assign half_valid_o = half_valid_q;
    assign half_data_o  = half_data_q;
    assign full_o       = w_full;
    assign empty_o      = w_empty;
    assign count_o      = w_count;
    assign overflow_o   = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_bsg_down_io_rx_buffer.sv
// ============================================================================
// Module      : tb_bsg_down_io_rx_buffer
// Description : Scoreboard bench for the IO receive byte-pair buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bsg_down_io_rx_buffer;

    localparam int c_DEPTH_LG = 6;
    localparam int c_TB       = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  io_valid_in = 1'b0;
    logic [7:0]            io_data_in = 8'h00;
    logic                  io_token_out;
    logic                  half_valid_o;
    logic [15:0]           half_data_o;
    logic                  half_ready_i = 1'b0;
    logic                  full_o;
    logic                  empty_o;
    logic [c_DEPTH_LG:0]   count_o;
    logic                  overflow_o;

    bsg_down_io_rx_buffer #(.DEPTH_LG(c_DEPTH_LG), .TOKEN_BATCH(c_TB)) dut (
        .clk          (clk),
        .rst          (rst),
        .io_valid_in  (io_valid_in),
        .io_data_in   (io_data_in),
        .io_token_out (io_token_out),
        .half_valid_o (half_valid_o),
        .half_data_o  (half_data_o),
        .half_ready_i (half_ready_i),
        .full_o       (full_o),
        .empty_o      (empty_o),
        .count_o      (count_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  pend_byte;
    bit          pend_valid = 1'b0;
    bit          mon_en = 1'b0;
    int          hs_cnt = 0;
    logic        tok_exp = 1'b0;
    int          tok_pulses = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Pair accepted bytes into expected half-words, first byte in the low half.
    task automatic model_accept(input logic [7:0] b);
        if (pend_valid) begin
            exp_q.push_back({b, pend_byte});
            pend_valid = 1'b0;
        end else begin
            pend_byte  = b;
            pend_valid = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit accepted);
        io_valid_in = 1'b1;
        io_data_in  = b;
        if (accepted) model_accept(b);
        tick();
        io_valid_in = 1'b0;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        io_valid_in  = 1'b0;
        exp_q.delete();
        pend_valid   = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        int budget;
        budget       = 400;
        half_ready_i = 1'b1;
        while ((exp_q.size() != 0 || half_valid_o) && budget > 0) begin
            tick();
            budget--;
        end
        check({tag, "_drain_done"}, (budget > 0) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Monitor: pops the scoreboard on every handshake and checks token timing.
    always @(negedge clk) begin
        if (mon_en) begin
            check("token", {31'd0, io_token_out}, {31'd0, tok_exp});
            if (io_token_out) tok_pulses++;
            tok_exp = 1'b0;
            if (rst) begin
                hs_cnt = 0;
            end else if (half_valid_o && half_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_output", {16'd0, half_data_o}, 32'hFFFF_FFFF);
                end else begin
                    check("sb_data", {16'd0, half_data_o}, {16'd0, exp_q.pop_front()});
                end
                hs_cnt++;
                if (hs_cnt == c_TB) begin
                    hs_cnt  = 0;
                    tok_exp = 1'b1;
                end
            end
        end
    end

    initial begin
        int idx;
        int budget;
        // Reset state
        tick();
        do_reset();
        mon_en = 1'b1;
        check("rst_valid", {31'd0, half_valid_o}, 32'd0);
        check("rst_data", {16'd0, half_data_o}, 32'd0);
        check("rst_count", {25'd0, count_o}, 32'd0);
        check("rst_empty", {31'd0, empty_o}, 32'd1);
        check("rst_full", {31'd0, full_o}, 32'd0);
        check("rst_ovf", {31'd0, overflow_o}, 32'd0);

        // 1) basic pair and latency
        half_ready_i = 1'b1;
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        check("t1_not_yet", {31'd0, half_valid_o}, 32'd0);
        tick();
        check("t1_valid", {31'd0, half_valid_o}, 32'd1);
        check("t1_data", {16'd0, half_data_o}, 32'h1234);
        tick();
        check("t1_valid_low", {31'd0, half_valid_o}, 32'd0);

        // 2) fill with ready low, overflow
        do_reset();
        half_ready_i = 1'b0;
        for (int i = 0; i < 70; i++) begin
            send_byte(8'(8'h40 + i), (i < 66) ? 1'b1 : 1'b0);
            if (i == 64) check("t2_not_full_64", {31'd0, full_o}, 32'd0);
            if (i == 65) begin
                check("t2_full_65", {31'd0, full_o}, 32'd1);
                check("t2_no_ovf_yet", {31'd0, overflow_o}, 32'd0);
            end
            if (i == 66) check("t2_ovf_set", {31'd0, overflow_o}, 32'd1);
        end
        check("t2_count", {25'd0, count_o}, 32'd64);
        check("t2_outreg", {16'd0, half_data_o}, 32'h4140);
        check("t2_outvalid", {31'd0, half_valid_o}, 32'd1);
        tick(); tick();
        check("t2_ovf_sticky", {31'd0, overflow_o}, 32'd1);
        drain("t2");
        check("t2_empty", {31'd0, empty_o}, 32'd1);
        check("t2_ovf_still", {31'd0, overflow_o}, 32'd1);

        // 3) token batching
        do_reset();
        half_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) send_byte(8'(8'h80 + i), 1'b1);
        tick(); tick();
        tok_pulses = 0;
        drain("t3");
        tick(); tick();
        check("t3_tokens", tok_pulses, 32'd2);

        // 4) random valid/ready stream with pointer wraps
        do_reset();
        idx = 0;
        budget = 5000;
        while (idx < 300 && budget > 0) begin
            half_ready_i = ($urandom_range(3) != 0);
            if ($urandom_range(1) == 1) begin
                io_valid_in = 1'b1;
                io_data_in  = 8'(idx);
                model_accept(8'(idx));
                idx++;
            end else begin
                io_valid_in = 1'b0;
            end
            tick();
            budget--;
        end
        io_valid_in = 1'b0;
        check("t4_sent_all", (budget > 0) ? 32'd1 : 32'd0, 32'd1);
        drain("t4");
        check("t4_sb_empty", exp_q.size(), 32'd0);
        check("t4_no_ovf", {31'd0, overflow_o}, 32'd0);
        check("t4_empty", {31'd0, empty_o}, 32'd1);

        // 5) odd byte waits for its partner
        do_reset();
        half_ready_i = 1'b1;
        send_byte(8'hAA, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        check("t5_wait_valid", {31'd0, half_valid_o}, 32'd0);
        check("t5_wait_count", {25'd0, count_o}, 32'd1);
        send_byte(8'hBB, 1'b1);
        tick();
        check("t5_valid", {31'd0, half_valid_o}, 32'd1);
        check("t5_data", {16'd0, half_data_o}, 32'hBBAA);
        tick();

        // 6) reset mid-stream with a held half-word
        half_ready_i = 1'b0;
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        send_byte(8'h77, 1'b1);
        tick();
        check("t6_pre_valid", {31'd0, half_valid_o}, 32'd1);
        do_reset();
        check("t6_valid", {31'd0, half_valid_o}, 32'd0);
        check("t6_data", {16'd0, half_data_o}, 32'd0);
        check("t6_count", {25'd0, count_o}, 32'd0);
        check("t6_token", {31'd0, io_token_out}, 32'd0);
        check("t6_ovf", {31'd0, overflow_o}, 32'd0);
        half_ready_i = 1'b1;
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        tick();
        check("t6_post_data", {16'd0, half_data_o}, 32'h0201);
        check("t6_post_valid", {31'd0, half_valid_o}, 32'd1);
        tick(); tick();
        check("t6_sb_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
